// File: rtl/paula_audio_volume_seq_pkg.sv
// Shared definitions for the Paula volume stage: default sizes, FSM states, helpers.
// Ramp behaviour is selected by PAULA_VOL_RAMP_EN (see paula_audio_vol_ramp).
package paula_audio_volume_seq_pkg;

   localparam int DEF_NCH = 4;
   localparam int DEF_SW  = 8;
   localparam int DEF_VW  = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Ceiling log2, never below 1 so a single-channel build still has a 1-bit index.
   function automatic int clog2min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int fullScale(input int vw);
      return 1 << (vw - 1);
   endfunction

endpackage

// File: rtl/paula_audio_vol_ramp.sv
// Per-channel volume register: clamps the target to full scale and, when
// PAULA_VOL_RAMP_EN is defined, steps one LSB toward it per accepted start.
module paula_audio_vol_ramp
   import paula_audio_volume_seq_pkg::*;
#(
   parameter int VW = DEF_VW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clk7_en,
   input  logic          load,
   input  logic [VW-1:0] target,
   output logic [VW-1:0] curVol
);

   localparam logic [VW-1:0] FULL = VW'(fullScale(VW));

   logic [VW-1:0] clamped;
   logic [VW-1:0] nextVol;

   always_comb begin
      clamped = (target > FULL) ? FULL : target;
`ifdef PAULA_VOL_RAMP_EN
      if (curVol < clamped)
         nextVol = curVol + 1'b1;
      else if (curVol > clamped)
         nextVol = curVol - 1'b1;
      else
         nextVol = curVol;
`else
      nextVol = clamped;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         curVol <= '0;
      else if (clk7_en && load)
         curVol <= nextVol;
   end

endmodule

// File: rtl/paula_audio_volume_seq.sv
// Time-multiplexed volume stage: one shared signed x unsigned multiplier walks all
// channels after each sample-period start. Optional ramping via PAULA_VOL_RAMP_EN.
module paula_audio_volume_seq
   import paula_audio_volume_seq_pkg::*;
#(
   parameter int NCH = DEF_NCH,
   parameter int SW  = DEF_SW,
   parameter int VW  = DEF_VW,
   localparam int OW = SW + VW,
   localparam int CW = clog2min1(NCH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clk7_en,
   input  logic                 start,
   input  logic [NCH*SW-1:0]    sample,
   input  logic [NCH*VW-1:0]    volume,
   output logic                 busy,
   output logic                 overrun,
   output logic                 out_valid,
   output logic [CW-1:0]        out_chan,
   output logic signed [OW-1:0] out
);

   state_t               state;
   logic [CW-1:0]        ch;
   logic signed [SW-1:0] holdSample [NCH];
   logic [VW-1:0]        curVol [NCH];
   logic                 accept;
   logic signed [OW-1:0] opSample;
   logic signed [OW-1:0] opVol;
   logic signed [OW-1:0] product;

   assign accept = clk7_en && start && (state == ST_IDLE);

   for (genvar k = 0; k < NCH; k++) begin : g_ramp
      paula_audio_vol_ramp #(.VW(VW)) u_ramp (
         .clk     (clk),
         .reset   (reset),
         .clk7_en (clk7_en),
         .load    (accept),
         .target  (volume[k*VW +: VW]),
         .curVol  (curVol[k])
      );
   end

   // Sample is sign-extended and volume zero-extended, so the product is exact in OW bits.
   always_comb begin
      opSample = OW'(holdSample[ch]);
      opVol    = signed'(OW'(curVol[ch]));
      product  = opSample * opVol;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         ch        <= '0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         out_valid <= 1'b0;
         out_chan  <= '0;
         out       <= '0;
         for (int k = 0; k < NCH; k++) holdSample[k] <= '0;
      end else if (clk7_en) begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_RUN;
                  ch      <= '0;
                  busy    <= 1'b1;
                  overrun <= 1'b0;
                  for (int k = 0; k < NCH; k++) holdSample[k] <= sample[k*SW +: SW];
               end
            end
            ST_RUN: begin
               if (start) overrun <= 1'b1;
               out_valid <= 1'b1;
               out_chan  <= ch;
               out       <= product;
               if (ch == CW'(NCH - 1))
                  state <= ST_DRAIN;
               else
                  ch <= ch + 1'b1;
            end
            ST_DRAIN: begin
               // A start seen here is still rejected; it is accepted next cycle from IDLE.
               if (start) overrun <= 1'b1;
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_paula_audio_volume_seq.sv
// Scoreboard bench for paula_audio_volume_seq; the ramp scenario is built when
// PAULA_VOL_RAMP_EN is defined, the fixed-volume scenarios otherwise.
module tb_paula_audio_volume_seq;

   localparam int NCH = 4;
   localparam int SW  = 8;
   localparam int VW  = 7;
   localparam int OW  = SW + VW;
   localparam int CW  = 2;

   localparam logic [NCH*SW-1:0] V2S = {8'hFF, 8'h01, 8'h80, 8'h7F};
   localparam logic [NCH*VW-1:0] V2V = {7'd64, 7'd64, 7'd64, 7'd64};

   typedef struct {
      int chan;
      int val;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 clk7_en;
   logic                 start;
   logic [NCH*SW-1:0]    sample;
   logic [NCH*VW-1:0]    volume;
   logic                 busy;
   logic                 overrun;
   logic                 out_valid;
   logic [CW-1:0]        out_chan;
   logic signed [OW-1:0] out;

   exp_t sbq[$];
   exp_t monExp;
   int   testsRun    = 0;
   int   testsFailed = 0;
   bit   gapMode     = 1'b0;

   always #5 clk = ~clk;

   paula_audio_volume_seq dut (
      .clk       (clk),
      .reset     (reset),
      .clk7_en   (clk7_en),
      .start     (start),
      .sample    (sample),
      .volume    (volume),
      .busy      (busy),
      .overrun   (overrun),
      .out_valid (out_valid),
      .out_chan  (out_chan),
      .out       (out)
   );

   task automatic checkOutput(input string name, input int act, input int exp);
      testsRun++;
      if (act != exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic pushExp(input int c, input int v);
      exp_t e;
      e.chan = c;
      e.val  = v;
      sbq.push_back(e);
   endtask

   // Advance to just after the next enabled edge; gap mode inserts three disabled cycles.
   task automatic enCycle();
      if (gapMode) begin
         clk7_en = 1'b0;
         repeat (3) begin
            @(posedge clk);
            #1;
         end
      end
      clk7_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Returns in cycle T+1 with inputs scrambled, since only latched values may matter.
   task automatic applyStimulus(input logic [NCH*SW-1:0] smp, input logic [NCH*VW-1:0] vol,
                                input int e0, input int e1, input int e2, input int e3);
      sample = smp;
      volume = vol;
      start  = 1'b1;
      pushExp(0, e0);
      pushExp(1, e1);
      pushExp(2, e2);
      pushExp(3, e3);
      enCycle();
      start  = 1'b0;
      sample = $urandom;
      volume = (NCH*VW)'($urandom);
   endtask

   // Monitor: one pop per enabled cycle that presents a result.
   always @(negedge clk) begin
      if (!reset && clk7_en && out_valid) begin
         if (sbq.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected result: chan %0d value %0d, expected none", out_chan, out);
         end else begin
            monExp = sbq.pop_front();
            checkOutput($sformatf("result chan (exp ch%0d)", monExp.chan), int'(out_chan), monExp.chan);
            checkOutput($sformatf("result value ch%0d", monExp.chan), int'(out), monExp.val);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset   = 1'b1;
      clk7_en = 1'b0;
      start   = 1'b0;
      sample  = '0;
      volume  = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset overrun", int'(overrun), 0);
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkOutput("reset out_chan", int'(out_chan), 0);
      checkOutput("reset out", int'(out), 0);
      reset   = 1'b0;
      clk7_en = 1'b1;

      // Reset during RUN abandons the sequence with no results.
      applyStimulus(V2S, V2V, 8128, -8192, 64, -64);
      checkOutput("t1 busy before reset", int'(busy), 1);
      reset = 1'b1;
      sbq.delete();
      #1;
      checkOutput("t1 busy after reset", int'(busy), 0);
      checkOutput("t1 out_valid after reset", int'(out_valid), 0);
      checkOutput("t1 out after reset", int'(out), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (6) enCycle();
      checkOutput("t1 busy idle", int'(busy), 0);

`ifdef PAULA_VOL_RAMP_EN
      for (int i = 1; i <= 66; i++) begin
         applyStimulus({8'h00, 8'h00, 8'h00, 8'h01}, {7'd0, 7'd0, 7'd0, 7'd64},
                       (i < 64) ? i : 64, 0, 0, 0);
         repeat (5) enCycle();
      end
      for (int j = 0; j < 5; j++) begin
         applyStimulus({8'h00, 8'h00, 8'h00, 8'h01}, {7'd0, 7'd0, 7'd0, 7'd60},
                       (63 - j < 60) ? 60 : 63 - j, 0, 0, 0);
         repeat (5) enCycle();
      end
`else
      // Full-scale extremes and busy window.
      applyStimulus(V2S, V2V, 8128, -8192, 64, -64);
      checkOutput("t2 busy T+1", int'(busy), 1);
      checkOutput("t2 out_valid T+1", int'(out_valid), 0);
      repeat (4) enCycle();
      checkOutput("t2 busy T+5", int'(busy), 1);
      checkOutput("t2 out_chan T+5", int'(out_chan), 3);
      enCycle();
      checkOutput("t2 busy T+6", int'(busy), 0);
      checkOutput("t2 out_valid T+6", int'(out_valid), 0);
      checkOutput("t2 out hold", int'(out), -64);

      // Volumes above full scale clamp to 64.
      applyStimulus({8'h40, 8'hF0, 8'h05, 8'h10}, {7'd0, 7'd65, 7'd10, 7'h7F},
                    1024, 50, -1024, 0);
      repeat (5) enCycle();

      // Start while busy raises sticky overrun without disturbing the sequence.
      applyStimulus({8'h05, 8'h04, 8'h03, 8'h02}, {7'd4, 7'd3, 7'd2, 7'd1}, 2, 6, 12, 20);
      enCycle();
      enCycle();
      start = 1'b1;
      enCycle();
      start = 1'b0;
      checkOutput("t4 overrun T+4", int'(overrun), 1);
      checkOutput("t4 busy T+4", int'(busy), 1);
      enCycle();
      enCycle();
      checkOutput("t4 busy T+6", int'(busy), 0);
      checkOutput("t4 overrun sticky", int'(overrun), 1);

      // Accepted start clears overrun; a start during DRAIN waits one cycle.
      applyStimulus({8'hFE, 8'h7F, 8'h80, 8'h03}, {7'd1, 7'd2, 7'd3, 7'd64},
                    192, -384, 254, -2);
      checkOutput("t4 overrun cleared", int'(overrun), 0);
      repeat (4) enCycle();
      sample = {8'h01, 8'h02, 8'h03, 8'h04};
      volume = {7'd8, 7'd8, 7'd8, 7'd8};
      start  = 1'b1;
      pushExp(0, 32);
      pushExp(1, 24);
      pushExp(2, 16);
      pushExp(3, 8);
      enCycle();
      checkOutput("t4 drain start rejected busy", int'(busy), 0);
      checkOutput("t4 drain start overrun", int'(overrun), 1);
      enCycle();
      start  = 1'b0;
      sample = $urandom;
      volume = (NCH*VW)'($urandom);
      checkOutput("t4 late start accepted busy", int'(busy), 1);
      checkOutput("t4 late start overrun clear", int'(overrun), 0);
      repeat (6) enCycle();

      // Sparse enable: same results, stretched; state frozen on disabled cycles.
      gapMode = 1'b1;
      applyStimulus(V2S, V2V, 8128, -8192, 64, -64);
      checkOutput("t6 busy T+1", int'(busy), 1);
      enCycle();
      clk7_en = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("t6 frozen out_valid", int'(out_valid), 1);
      checkOutput("t6 frozen out_chan", int'(out_chan), 0);
      repeat (4) enCycle();
      checkOutput("t6 busy end", int'(busy), 0);
      gapMode = 1'b0;
      clk7_en = 1'b1;
`endif

      for (int w = 0; w < 100 && sbq.size() != 0; w++) @(posedge clk);
      #1;
      checkOutput("scoreboard drained", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
